// File: rtl/sb_io_debounced_input.sv
// Pad input through SB_IO, two-flop resynchroniser, counter debounce, registered
// rise/fall strobes and a wrapping rising-edge event counter.

`ifndef SYNTHESIS
// Behavioural stand-in for the iCE40 SB_IO primitive (simple-input subset) so the block simulates standalone.
module SB_IO #(
    parameter logic [5:0] PIN_TYPE    = 6'b000000,
    parameter logic       PULLUP      = 1'b0,
    parameter             IO_STANDARD = "SB_LVCMOS"
) (
    input  logic PACKAGE_PIN,
    output logic D_IN_0
);
    assign D_IN_0 = ((PIN_TYPE[1:0] == 2'b01) && (IO_STANDARD == "SB_LVCMOS")) ? PACKAGE_PIN : PULLUP;
endmodule
`endif

module sb_io_debounced_input #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   CNT_W           = 5,
    parameter int   EVENT_W         = 8,
    parameter logic PULLUP          = 1'b1,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pin,
    input  logic               count_clr,
    output logic               level,
    output logic               rise,
    output logic               fall,
    output logic [EVENT_W-1:0] event_count
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               pad_in_s;
    logic               sync1_r;
    logic               sync2_r;
    logic               level_r;
    logic               rise_r;
    logic               fall_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [EVENT_W-1:0] event_count_r;
    logic               flip_s;
    logic               rise_s;

    SB_IO #(
        .PIN_TYPE   (6'b000001),
        .PULLUP     (PULLUP),
        .IO_STANDARD("SB_LVCMOS")
    ) pad_io (
        .PACKAGE_PIN(pin),
        .D_IN_0     (pad_in_s)
    );

    // Resynchronise the pad sample into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= RESET_LEVEL;
            sync2_r <= RESET_LEVEL;
        end else begin
            sync1_r <= pad_in_s;
            sync2_r <= sync1_r;
        end
    end

    // Flip decision: this is the Nth consecutive cycle the synced value disagrees with level.
    always_comb begin
        flip_s = 1'b0;
        rise_s = 1'b0;
        if ((sync2_r != level_r) && (cnt_r == CNT_LAST)) begin
            flip_s = 1'b1;
            rise_s = sync2_r;
        end else begin
            flip_s = 1'b0;
            rise_s = 1'b0;
        end
    end

    // Debounce counter, level register and one-cycle strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_r <= RESET_LEVEL;
            cnt_r   <= '0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= rise_s;
            fall_r <= flip_s & ~sync2_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (flip_s) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Rising-edge event counter; a clear on the same edge as a rise keeps that rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            event_count_r <= '0;
        end else if (count_clr) begin
            event_count_r <= {{(EVENT_W-1){1'b0}}, rise_s};
        end else if (rise_s) begin
            event_count_r <= event_count_r + EVENT_W'(1);
        end else begin
            event_count_r <= event_count_r;
        end
    end

    assign level       = level_r;
    assign rise        = rise_r;
    assign fall        = fall_r;
    assign event_count = event_count_r;

endmodule

// File: tb/tb_sb_io_debounced_input.sv
// Self-checking bench: vector table, hand-written timing sequences and random stimulus,
// all compared cycle by cycle against a sliding-window reference model.
module tb_sb_io_debounced_input;
    localparam int   D  = 16;
    localparam int   EW = 8;
    localparam logic RL = 1'b1;

    logic          clock = 1'b0;
    logic          reset;
    logic          pin;
    logic          count_clr;
    logic          level;
    logic          rise;
    logic          fall;
    logic [EW-1:0] event_count;

    int checks = 0;
    int errors = 0;

    // Reference model: level flips when the last D resynchronised samples all disagree with it.
    logic          m_level;
    logic          m_rise;
    logic          m_fall;
    logic [EW-1:0] m_ev;
    logic          mq[$];
    int            seg_r;
    int            seg_f;

    sb_io_debounced_input #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (5),
        .EVENT_W        (EW),
        .PULLUP         (1'b1),
        .RESET_LEVEL    (RL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pin        (pin),
        .count_clr  (count_clr),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .event_count(event_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic all_diff;
        if (reset) begin
            mq.delete();
            for (int i = 0; i < D + 2; i++) mq.push_back(RL);
            m_level = RL;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_ev    = '0;
        end else begin
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++)
                if (mq[mq.size() - 1 - k] == m_level) all_diff = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (all_diff) begin
                m_level = ~m_level;
                if (m_level) m_rise = 1'b1;
                else         m_fall = 1'b1;
            end
            if (count_clr)   m_ev = m_rise ? 8'd1 : 8'd0;
            else if (m_rise) m_ev = m_ev + 8'd1;
            mq.push_back(pin);
            if (mq.size() > D + 2) void'(mq.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("level", 32'(level), 32'(m_level));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("event_count", 32'(event_count), 32'(m_ev));
        if (rise) seg_r++;
        if (fall) seg_f++;
    endtask

    typedef struct {
        logic rst;
        logic p;
        logic clr;
        int   cycles;
        logic exp_level;
        int   exp_rise;
        int   exp_fall;
        int   exp_ev;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [0:NV-1];

    initial begin
        int n;
        bit found;
        int hold;

        vecs[0]  = '{1'b1, 1'b1, 1'b0,  3, 1'b1, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 50, 1'b1, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 15, 1'b1, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 20, 1'b1, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16, 1'b1, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 40, 1'b1, 1, 1, 1};
        for (int i = 0; i < 10; i++)
            vecs[6 + i] = '{1'b0, logic'(i % 2), 1'b0, 3, 1'b1, 0, 0, 1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 30, 1'b0, 0, 1, 1};
        vecs[17] = '{1'b0, 1'b0, 1'b1,  1, 1'b0, 0, 0, 0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 30, 1'b1, 1, 0, 1};
        vecs[19] = '{1'b1, 1'b0, 1'b0,  2, 1'b1, 0, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 30, 1'b0, 0, 1, 0};

        reset = 1'b1;
        pin = 1'b1;
        count_clr = 1'b0;

        for (int v = 0; v < NV; v++) begin
            reset = vecs[v].rst;
            pin = vecs[v].p;
            count_clr = vecs[v].clr;
            seg_r = 0;
            seg_f = 0;
            repeat (vecs[v].cycles) step();
            chk($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
            chk($sformatf("vec%0d_rises", v), 32'(seg_r), 32'(vecs[v].exp_rise));
            chk($sformatf("vec%0d_falls", v), 32'(seg_f), 32'(vecs[v].exp_fall));
            chk($sformatf("vec%0d_count", v), 32'(event_count), 32'(vecs[v].exp_ev));
        end
        reset = 1'b0;
        count_clr = 1'b0;

        // Clean falling edge: fall appears exactly 18 edges after the pin change.
        pin = 1'b1;
        repeat (30) step();
        pin = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (fall) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("clean_fall_latency", 32'(n), 32'd18);
        chk("clean_fall_level", 32'(level), 32'd0);

        // Reset while a debounce is ten counts in; fall must restart from release.
        pin = 1'b1;
        repeat (30) step();
        pin = 1'b0;
        repeat (12) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_level", 32'(level), 32'd1);
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (fall) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("midreset_fall_latency", 32'(n), 32'd18);

        // 257 pulses wrap the 8-bit counter to 1.
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        for (int p = 0; p < 257; p++) begin
            pin = 1'b0;
            repeat (20) step();
            pin = 1'b1;
            repeat (20) step();
        end
        chk("wrap_count", 32'(event_count), 32'd1);

        // Clear on the same edge as a rise keeps that rise.
        pin = 1'b0;
        repeat (20) step();
        pin = 1'b1;
        repeat (17) step();
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        chk("clr_with_rise_strobe", 32'(rise), 32'd1);
        chk("clr_with_rise_count", 32'(event_count), 32'd1);

        // Random holds, bounces, clears and occasional resets.
        for (int c = 0; c < 3000; c += hold) begin
            hold = $urandom_range(1, 40);
            pin = logic'($urandom_range(0, 1));
            for (int j = 0; j < hold; j++) begin
                count_clr = ($urandom_range(0, 49) == 0);
                reset = ($urandom_range(0, 299) == 0);
                step();
            end
        end
        reset = 1'b0;
        count_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
